// File: rtl/seg_pkg.sv
// Shared constants, font and message tables for the 7-segment display controller.
// All glyphs are active-low with bit order gfedcba.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam int MSG_LEN = 8;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_LOSE   = 2'd1,
        MODE_WIN    = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    // "You LoSE" and "good job", element 0 is the leftmost digit
    localparam logic [6:0] MSG_LOSE [MSG_LEN] = '{
        ~7'h6E, ~7'h5C, ~7'h1C, SEG_BLANK, ~7'h38, ~7'h5C, ~7'h6D, ~7'h79
    };
    localparam logic [6:0] MSG_WIN [MSG_LEN] = '{
        ~7'h6F, ~7'h5C, ~7'h5C, ~7'h5E, SEG_BLANK, ~7'h0E, ~7'h5C, ~7'h7C
    };

    // Nibble to glyph: 0-9, A b C d E; F is blank
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    return ~7'h3F;
            4'h1:    return ~7'h06;
            4'h2:    return ~7'h5B;
            4'h3:    return ~7'h4F;
            4'h4:    return ~7'h66;
            4'h5:    return ~7'h6D;
            4'h6:    return ~7'h7D;
            4'h7:    return ~7'h07;
            4'h8:    return ~7'h7F;
            4'h9:    return ~7'h6F;
            4'hA:    return ~7'h77;
            4'hB:    return ~7'h7C;
            4'hC:    return ~7'h39;
            4'hD:    return ~7'h5E;
            4'hE:    return ~7'h79;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Banner glyph for a digit position; positions past the message are blank
    function automatic logic [6:0] msg_glyph(input logic is_win, input int idx);
        logic [2:0] sel;
        if (idx < 0 || idx >= MSG_LEN) return SEG_BLANK;
        sel = idx[2:0];
        return is_win ? MSG_WIN[sel] : MSG_LOSE[sel];
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Bus between the game FSM (master) and the segment display controller (slave).
interface seg_display_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int FIELD_W    = 7
);
    logic                    load;
    logic [FIELD_W-1:0]      value;
    logic                    busy;
    logic [1:0]              mode;
    logic [NUM_DIGITS*4-1:0] raw_digits;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS*7-1:0] seg;

    modport master (
        output load, value, mode, raw_digits, digit_en,
        input  busy, seg
    );

    modport slave (
        input  load, value, mode, raw_digits, digit_en,
        output busy, seg
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// The captured source value is held alongside the result for range checks.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int FIELD_W      = 7,
    parameter int FIELD_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      restart,
    input  logic                      start,
    input  logic [FIELD_W-1:0]        bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [FIELD_DIGITS*4-1:0] bcd,
    output logic [FIELD_W-1:0]        src
);

    localparam int CW = $clog2(FIELD_W + 1);

    conv_state_t               state, state_next;
    logic [FIELD_W-1:0]        shift_bin, bin_next;
    logic [FIELD_W-1:0]        src_reg, src_next;
    logic [FIELD_DIGITS*4-1:0] bcd_reg, bcd_next, adjusted;
    logic [CW-1:0]             count, count_next;

    // State and datapath registers; restart aborts any conversion in flight
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            state     <= CONV_IDLE;
            shift_bin <= '0;
            src_reg   <= '0;
            bcd_reg   <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            shift_bin <= bin_next;
            src_reg   <= src_next;
            bcd_reg   <= bcd_next;
            count     <= count_next;
        end
    end

    // Add 3 to every BCD digit that is 5 or more before the next shift
    always_comb begin
        adjusted = bcd_reg;
        for (int d = 0; d < FIELD_DIGITS; d++) begin
            if (bcd_reg[d*4 +: 4] >= 4'd5) begin
                adjusted[d*4 +: 4] = bcd_reg[d*4 +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath update for IDLE -> SHIFT x FIELD_W -> DONE
    always_comb begin
        state_next = state;
        bin_next   = shift_bin;
        src_next   = src_reg;
        bcd_next   = bcd_reg;
        count_next = count;
        unique case (state)
            CONV_IDLE: begin
                if (start) begin
                    src_next   = bin_in;
                    bin_next   = bin_in;
                    bcd_next   = '0;
                    count_next = '0;
                    state_next = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                bcd_next   = {adjusted[FIELD_DIGITS*4-2:0], shift_bin[FIELD_W-1]};
                bin_next   = {shift_bin[FIELD_W-2:0], 1'b0};
                count_next = count + 1'b1;
                if (count == CW'(FIELD_W - 1)) begin
                    state_next = CONV_DONE;
                end
            end
            CONV_DONE: begin
                state_next = CONV_IDLE;
            end
            default: begin
                state_next = CONV_IDLE;
            end
        endcase
    end

    assign busy = (state != CONV_IDLE);
    assign done = (state == CONV_DONE);
    assign bcd  = bcd_reg;
    assign src  = src_reg;

endmodule

// File: rtl/seg_display_ctrl.sv
// Registered driver for a bank of active-low 7-segment digits: a converted
// numeric field with blanking/overflow/blink, raw nibble digits, and banners.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int FIELD_W      = 7,
    parameter int FIELD_DIGITS = 2,
    parameter int BLINK_HALF   = 25_000_000,
    parameter int BLINK_THRESH = 10
) (
    input logic               clk,
    input logic               restart,
    seg_display_ctrl_if.slave bus
);

    localparam logic [31:0] FIELD_MAX = 32'(10 ** FIELD_DIGITS - 1);
    localparam logic [31:0] THRESH    = 32'(BLINK_THRESH);
    localparam int          BCW       = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic                      conv_busy;
    logic                      conv_done;
    logic [FIELD_DIGITS*4-1:0] conv_bcd;
    logic [FIELD_W-1:0]        conv_src;

    logic [FIELD_DIGITS*4-1:0] field_bcd;
    logic                      field_valid;
    logic                      field_ovf;
    logic                      field_low;

    logic [BCW-1:0]            blink_cnt;
    logic                      blink_on;

    logic [6:0]                field_glyph [FIELD_DIGITS];
    logic [3:0]                nib;
    logic                      seen_nonzero;
    logic [NUM_DIGITS*7-1:0]   seg_next;
    logic [NUM_DIGITS*7-1:0]   seg_reg;
    mode_t                     mode_sel;
    logic                      unused_field_nibbles;

    assign mode_sel             = mode_t'(bus.mode);
    assign unused_field_nibbles = ^bus.raw_digits[FIELD_DIGITS*4-1:0];

    bin2bcd_seq #(
        .FIELD_W      (FIELD_W),
        .FIELD_DIGITS (FIELD_DIGITS)
    ) u_conv (
        .clk     (clk),
        .restart (restart),
        .start   (bus.load),
        .bin_in  (bus.value),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (conv_bcd),
        .src     (conv_src)
    );

    // Commit the finished conversion together with its range flags
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            field_bcd   <= '0;
            field_valid <= 1'b0;
            field_ovf   <= 1'b0;
            field_low   <= 1'b0;
        end else if (conv_done) begin
            field_bcd   <= conv_bcd;
            field_valid <= 1'b1;
            field_ovf   <= (32'(conv_src) > FIELD_MAX);
            field_low   <= (32'(conv_src) < THRESH);
        end
    end

    // Free-running blink timebase, toggling every BLINK_HALF cycles
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BCW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Field digit glyphs: overflow dash, then blink, then leading-zero blank
    always_comb begin
        nib          = '0;
        seen_nonzero = 1'b0;
        for (int p = 0; p < FIELD_DIGITS; p++) begin
            nib = field_bcd[(FIELD_DIGITS-1-p)*4 +: 4];
            if (nib != 4'd0) begin
                seen_nonzero = 1'b1;
            end
            if (!field_valid) begin
                field_glyph[p] = SEG_BLANK;
            end else if (field_ovf) begin
                field_glyph[p] = SEG_DASH;
            end else if (field_low && !blink_on) begin
                field_glyph[p] = SEG_BLANK;
            end else if (!seen_nonzero && p != FIELD_DIGITS - 1) begin
                field_glyph[p] = SEG_BLANK;
            end else begin
                field_glyph[p] = glyph(nib);
            end
        end
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        logic [6:0] base_glyph;
        logic [6:0] out_glyph;

        if (d < FIELD_DIGITS) begin : g_field
            assign base_glyph = field_glyph[d];
        end else begin : g_raw
            assign base_glyph = glyph(bus.raw_digits[d*4 +: 4]);
        end

        // Per-digit selection: enable first, then display mode
        always_comb begin
            out_glyph = SEG_BLANK;
            if (bus.digit_en[d]) begin
                case (mode_sel)
                    MODE_NORMAL: out_glyph = base_glyph;
                    MODE_LOSE:   out_glyph = msg_glyph(1'b0, d);
                    MODE_WIN:    out_glyph = msg_glyph(1'b1, d);
                    default:     out_glyph = SEG_BLANK;
                endcase
            end
        end

        assign seg_next[d*7 +: 7] = out_glyph;
    end

    // Output register so the segment pins never see combinational glitches
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            seg_reg <= '1;
        end else begin
            seg_reg <= seg_next;
        end
    end

    assign bus.seg  = seg_reg;
    assign bus.busy = conv_busy;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: expectations are queued with the
// cycle they are due and compared on the falling edge of that cycle.
module tb_seg_display_ctrl;

    localparam int ND = 8;
    localparam int FW = 7;
    localparam int FD = 2;
    localparam int BH = 4;
    localparam int BT = 10;

    // Active-high gfedcba patterns
    localparam logic [6:0] FONT_LIT [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h00
    };
    localparam logic [6:0] LOSE_LIT [0:7] = '{
        7'h6E, 7'h5C, 7'h1C, 7'h00, 7'h38, 7'h5C, 7'h6D, 7'h79
    };
    localparam logic [6:0] WIN_LIT [0:7] = '{
        7'h6F, 7'h5C, 7'h5C, 7'h5E, 7'h00, 7'h0E, 7'h5C, 7'h7C
    };

    logic clk = 1'b0;
    logic restart;
    int   cyc = 0;
    int   test_count = 0;
    int   fail_count = 0;
    int   cur_val;
    bit   cur_valid;

    string       tag_q [$];
    int          tgt_q [$];
    int          kind_q[$];
    logic [55:0] exp_q [$];

    seg_display_ctrl_if #(.NUM_DIGITS(ND), .FIELD_W(FW)) bus ();

    seg_display_ctrl #(
        .NUM_DIGITS   (ND),
        .FIELD_W      (FW),
        .FIELD_DIGITS (FD),
        .BLINK_HALF   (BH),
        .BLINK_THRESH (BT)
    ) dut (
        .clk     (clk),
        .restart (restart),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release
    always @(posedge clk or posedge restart) begin
        if (restart) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check_output(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        test_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Blink state governing the seg value registered at edge e
    function automatic bit blink_at(input int e);
        return (((e - 1) / BH) % 2) == 0;
    endfunction

    function automatic logic [55:0] exp_seg(input int fval, input bit fvalid, input int e);
        logic [55:0] r;
        logic [6:0]  lit;
        bit          bon;
        int          tens;
        int          ones;
        r    = '1;
        bon  = blink_at(e);
        tens = fval / 10;
        ones = fval % 10;
        for (int d = 0; d < ND; d++) begin
            lit = 7'h00;
            if (bus.digit_en[d]) begin
                case (bus.mode)
                    2'd1: lit = LOSE_LIT[d];
                    2'd2: lit = WIN_LIT[d];
                    2'd0: begin
                        if (d < FD) begin
                            if (fvalid) begin
                                if (fval > 99)                lit = 7'h40;
                                else if (fval < BT && !bon)   lit = 7'h00;
                                else if (d == 0)              lit = (tens == 0) ? 7'h00 : FONT_LIT[tens];
                                else                          lit = FONT_LIT[ones];
                            end
                        end else begin
                            lit = FONT_LIT[bus.raw_digits[d*4 +: 4]];
                        end
                    end
                    default: lit = 7'h00;
                endcase
            end
            r[d*7 +: 7] = ~lit;
        end
        return r;
    endfunction

    task automatic push_seg(input string tag, input int e, input int fval, input bit fvalid);
        tag_q.push_back(tag);
        tgt_q.push_back(e);
        kind_q.push_back(0);
        exp_q.push_back(exp_seg(fval, fvalid, e));
    endtask

    task automatic push_busy(input string tag, input int e, input bit b);
        tag_q.push_back(tag);
        tgt_q.push_back(e);
        kind_q.push_back(1);
        exp_q.push_back(56'(b));
    endtask

    // Compare every expectation due this cycle; overdue ones count as failures
    always @(negedge clk) begin
        for (int i = tgt_q.size() - 1; i >= 0; i--) begin
            if (tgt_q[i] <= cyc) begin
                if (tgt_q[i] < cyc)
                    check_output({tag_q[i], "_missed"}, 56'(cyc), 56'(tgt_q[i]));
                else if (kind_q[i] == 0)
                    check_output(tag_q[i], bus.seg, exp_q[i]);
                else
                    check_output(tag_q[i], 56'(bus.busy), exp_q[i]);
                tag_q.delete(i);
                tgt_q.delete(i);
                kind_q.delete(i);
                exp_q.delete(i);
            end
        end
    end

    task automatic drain();
        int waited;
        waited = 0;
        while (tgt_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (tgt_q.size() != 0) begin
            check_output("drain_timeout", 56'(tgt_q.size()), 56'd0);
            tag_q.delete();
            tgt_q.delete();
            kind_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic check_window(input string tag, input int n);
        for (int k = 1; k <= n; k++) push_seg(tag, cyc + k, cur_val, cur_valid);
        drain();
    endtask

    // Load a value; optionally fire a second load while the first is busy
    task automatic apply_load(input int v, input int intrude);
        int n;
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = FW'(v);
        n = cyc + 1;
        push_busy($sformatf("busy_start_%0d", v), n, 1'b1);
        push_busy($sformatf("busy_hold_%0d", v), n + 7, 1'b1);
        push_busy($sformatf("busy_drop_%0d", v), n + 8, 1'b0);
        push_seg($sformatf("seg_old_%0d", v), n + 8, cur_val, cur_valid);
        push_seg($sformatf("seg_new_%0d", v), n + 9, v, 1'b1);
        push_seg($sformatf("seg_next_%0d", v), n + 10, v, 1'b1);
        @(negedge clk);
        bus.load = 1'b0;
        if (intrude >= 0) begin
            repeat (2) @(negedge clk);
            bus.load  = 1'b1;
            bus.value = FW'(intrude);
            @(negedge clk);
            bus.load = 1'b0;
        end
        cur_val   = v;
        cur_valid = 1'b1;
        drain();
    endtask

    initial begin
        int vals [7] = '{90, 99, 100, 10, 9, 7, 0};

        restart        = 1'b1;
        bus.load       = 1'b1;
        bus.value      = 7'd33;
        bus.mode       = 2'd0;
        bus.raw_digits = 32'hEFA3_2188;
        bus.digit_en   = 8'hFF;
        cur_val        = 0;
        cur_valid      = 1'b0;

        repeat (3) @(negedge clk);
        check_output("reset_seg", bus.seg, {56{1'b1}});
        check_output("reset_busy", 56'(bus.busy), 56'd0);
        restart  = 1'b0;
        bus.load = 1'b0;
        push_seg("post_reset_field_blank", cyc + 2, 0, 1'b0);
        push_busy("post_reset_busy", cyc + 2, 1'b0);
        drain();

        for (int i = 0; i < 7; i++) begin
            apply_load(vals[i], -1);
            if (vals[i] < BT) check_window($sformatf("blink_%0d", vals[i]), 8);
        end

        apply_load(120, 5);
        check_window("ovf_hold", 10);

        apply_load(7, -1);
        @(negedge clk); bus.mode = 2'd1;
        check_window("mode_lose", 2);
        @(negedge clk); bus.mode = 2'd2;
        check_window("mode_win", 2);
        @(negedge clk); bus.digit_en = 8'hF7;
        check_window("win_en3_off", 2);
        @(negedge clk); bus.mode = 2'd3;
        check_window("mode_blank", 2);
        @(negedge clk);
        bus.mode       = 2'd0;
        bus.digit_en   = 8'hFD;
        bus.raw_digits = 32'h9DC4_B0FF;
        check_window("normal_en1_off", 8);

        @(negedge clk); bus.load = 1'b1; bus.value = 7'd55;
        @(negedge clk); bus.load = 1'b0;
        repeat (2) @(negedge clk);
        restart = 1'b1;
        #1;
        check_output("abort_busy", 56'(bus.busy), 56'd0);
        check_output("abort_seg", bus.seg, {56{1'b1}});
        cur_val   = 0;
        cur_valid = 1'b0;
        @(negedge clk);
        restart = 1'b0;
        push_busy("post_abort_busy", cyc + 1, 1'b0);
        check_window("post_abort_blank", 12);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish by 100000, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
